// File: rtl/axi_read_arbiter_if.sv
// AXI4 read address and read data channels between the arbiter (master) and memory (slave).
interface axi_read_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rid, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rid, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter, one outstanding burst at a time.
// Define AXI_READ_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to the data side.
module axi_read_arbiter #(
    parameter int unsigned ARLEN_MAX = 15
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [31:0]         req_addr0,
    input  logic [31:0]         req_addr1,
    input  logic [3:0]          req_len0,
    input  logic [3:0]          req_len1,
    output logic [1:0]          req_ready,
    output logic [31:0]         resp_data,
    output logic [1:0]          resp_valid,
    output logic                resp_last,
    axi_read_arbiter_if.master  axi
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q;
    logic        winner_q;
    logic [31:0] araddr_q;
    logic [3:0]  arlen_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        pick;
    logic        in_data;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if ({28'd0, len} > ARLEN_MAX) begin
            return ARLEN_MAX[3:0];
        end
        return len;
    endfunction

`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_comb begin
        pick = req_valid[1];
        if (req_valid == 2'b11) begin
            pick = ~last_grant_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (state_q == StIdle && |req_valid) begin
            last_grant_q <= pick;
        end
    end
`else
    always_comb begin
        pick = req_valid[1];
    end
`endif

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q   <= StIdle;
            winner_q  <= 1'b0;
            araddr_q  <= 32'd0;
            arlen_q   <= 4'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        winner_q  <= pick;
                        araddr_q  <= pick ? req_addr1 : req_addr0;
                        arlen_q   <= clamp_len(pick ? req_len1 : req_len0);
                        arvalid_q <= 1'b1;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (axi.rvalid && axi.rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign axi.arid    = {3'b000, winner_q};
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    // Beats arriving while reset is asserted belong to an aborted burst and are dropped.
    assign in_data   = (state_q == StData) && !reset;
    assign resp_data = axi.rdata;

    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_last  = 1'b0;
        if (state_q == StAddr && arvalid_q && axi.arready) begin
            req_ready[winner_q] = 1'b1;
        end
        if (in_data && axi.rvalid) begin
            resp_valid[winner_q] = 1'b1;
            resp_last            = axi.rlast;
        end
    end

    // Routing uses the latched winner only; response ID and status are ignored.
    logic unused_rinfo;
    assign unused_rinfo = ^{axi.rid, axi.rresp};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed and randomized bench for axi_read_arbiter with a request-set reference model.
module tb_axi_read_arbiter;
    localparam int unsigned LMAX = 7;

    logic        aclk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_addr0, req_addr1;
    logic [3:0]  req_len0, req_len1;
    logic [1:0]  req_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_valid;
    logic        resp_last;

    axi_read_arbiter_if axi ();

    axi_read_arbiter #(.ARLEN_MAX(LMAX)) dut (
        .aclk       (aclk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_len0   (req_len0),
        .req_len1   (req_len1),
        .req_ready  (req_ready),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_last  (resp_last),
        .axi        (axi)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: pending request set, per-side address/length, last granted side.
    logic [1:0]  pend;
    logic [31:0] m_addr [2];
    logic [3:0]  m_len  [2];
    int          last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] p, input int lst);
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
        if (p == 2'b11) return (lst + 1) % 2;
`endif
        if (p[1]) return 1;
        return 0;
    endfunction

    function automatic int beats_of(input logic [3:0] l);
        int n;
        n = int'(l);
        if (n > int'(LMAX)) n = int'(LMAX);
        return n + 1;
    endfunction

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_req();
        req_valid = pend;
        req_addr0 = m_addr[0];
        req_addr1 = m_addr[1];
        req_len0  = m_len[0];
        req_len1  = m_len[1];
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic raise(input int s, input logic [31:0] a, input logic [3:0] l);
        pend[s]   = 1'b1;
        m_addr[s] = a;
        m_len[s]  = l;
        drive_req();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend = 2'b00;
        drive_req();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        last = 1;
    endtask

    // Entered at posedge+1 with the DUT idle; runs one full grant and burst.
    task automatic run_burst(input string tag, input int ar_delay, input int gap_max,
                             input bit mid_raise);
        int w;
        int n;
        int gaps;
        logic [31:0] d;
        w = model_pick(pend, last);
        n = beats_of(m_len[w]);
        drive_req();
        @(negedge aclk);
        check($sformatf("%s.idle_arvalid", tag), axi.arvalid, 1'b0);
        check($sformatf("%s.idle_rready", tag), axi.rready, 1'b0);
        tick();
        last = w;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge aclk);
            check($sformatf("%s.bp_arvalid", tag), axi.arvalid, 1'b1);
            check($sformatf("%s.bp_araddr", tag), axi.araddr, m_addr[w]);
            check($sformatf("%s.bp_arlen", tag), axi.arlen, beats_of(m_len[w]) - 1);
            check($sformatf("%s.bp_req_ready", tag), req_ready, 2'b00);
            tick();
        end
        axi.arready = 1'b1;
        @(negedge aclk);
        check($sformatf("%s.arvalid", tag), axi.arvalid, 1'b1);
        check($sformatf("%s.arid", tag), axi.arid, w);
        check($sformatf("%s.araddr", tag), axi.araddr, m_addr[w]);
        check($sformatf("%s.arlen", tag), axi.arlen, n - 1);
        check($sformatf("%s.req_ready", tag), req_ready, onehot(w));
        tick();
        axi.arready = 1'b0;
        pend[w] = 1'b0;
        drive_req();
        for (int b = 0; b < n; b++) begin
            if (mid_raise && pend != 2'b11 && $urandom_range(3, 0) == 0) begin
                raise(pend[0] ? 1 : 0, $urandom, 4'($urandom_range(15, 0)));
            end
            gaps = $urandom_range(gap_max, 0);
            for (int g = 0; g < gaps; g++) begin
                axi.rvalid = 1'b0;
                @(negedge aclk);
                check($sformatf("%s.gap_rready", tag), axi.rready, 1'b1);
                check($sformatf("%s.gap_resp_valid", tag), resp_valid, 2'b00);
                tick();
            end
            d = $urandom;
            axi.rdata  = d;
            axi.rresp  = 2'($urandom_range(3, 0));
            axi.rid    = 4'($urandom_range(15, 0));
            axi.rvalid = 1'b1;
            axi.rlast  = (b == n - 1);
            @(negedge aclk);
            check($sformatf("%s.resp_valid", tag), resp_valid, onehot(w));
            check($sformatf("%s.resp_data", tag), resp_data, d);
            check($sformatf("%s.resp_last", tag), resp_last, (b == n - 1));
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    initial begin
        axi.rdata = '0;
        axi.rresp = '0;
        axi.rid   = '0;
        m_addr[0] = '0;
        m_addr[1] = '0;
        m_len[0]  = '0;
        m_len[1]  = '0;
        do_reset();

        @(negedge aclk);
        check("rst.arvalid", axi.arvalid, 1'b0);
        check("rst.rready", axi.rready, 1'b0);
        check("rst.req_ready", req_ready, 2'b00);
        check("rst.resp_valid", resp_valid, 2'b00);
        check("rst.resp_last", resp_last, 1'b0);
        check("rst.araddr", axi.araddr, 32'd0);
        check("rst.arlen", axi.arlen, 4'd0);
        check("rst.arid", axi.arid, 4'd0);
        check("rst.arsize", axi.arsize, 3'b010);
        check("rst.arburst", axi.arburst, 2'b01);
        tick();

        // Single instruction-side request.
        raise(0, 32'h1FC0_0000, 4'd3);
        run_burst("single", 0, 0, 1'b0);

        // Address-channel backpressure on the data side.
        raise(1, 32'h8000_1000, 4'd5);
        run_burst("backpressure", 5, 1, 1'b0);

        // Over-long request is clamped to LMAX.
        raise(0, 32'h0000_4000, 4'd12);
        run_burst("clamp", 0, 0, 1'b0);

        // Simultaneous requests straight after reset; loser stays pending.
        do_reset();
        raise(0, 32'h0000_0100, 4'd2);
        raise(1, 32'h0000_0200, 4'd1);
        run_burst("both_first", 0, 0, 1'b0);
        check("both.pending_left", pend, 2'b01 << (1 - last));
        run_burst("both_second", 0, 0, 1'b0);

        // Reset in the middle of an 8-beat burst.
        raise(1, 32'h0000_8000, 4'd7);
        tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        pend = 2'b00;
        drive_req();
        for (int b = 0; b < 2; b++) begin
            axi.rdata  = $urandom;
            axi.rvalid = 1'b1;
            axi.rlast  = 1'b0;
            @(negedge aclk);
            check("abort.pre_resp_valid", resp_valid, 2'b10);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last = 1;
        for (int c = 0; c < 3; c++) begin
            axi.rdata = $urandom;
            @(negedge aclk);
            check("abort.rready", axi.rready, 1'b0);
            check("abort.resp_valid", resp_valid, 2'b00);
            check("abort.resp_last", resp_last, 1'b0);
            check("abort.arvalid", axi.arvalid, 1'b0);
            tick();
        end
        axi.rvalid = 1'b0;
        raise(0, 32'h0000_C000, 4'd1);
        run_burst("after_abort", 1, 0, 1'b0);

        // Randomized traffic with pending losers and requests raised mid-burst.
        for (int t = 0; t < 40; t++) begin
            if (pend == 2'b00) begin
                int s;
                s = $urandom_range(2, 0);
                if (s != 1) raise(1, $urandom, 4'($urandom_range(15, 0)));
                if (s != 0) raise(0, $urandom, 4'($urandom_range(15, 0)));
            end
            run_burst("rand", $urandom_range(3, 0), 2, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter: ARLEN_MAX, default 15, largest legal req_lenN value; larger values are clamped to it.
REQ-002 aclk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester read request; bit0 = instruction side, bit1 = data side.
REQ-005 req_addr0 / req_addr1  in  32 each  burst start address, one per requester.
REQ-006 req_len0 / req_len1  in  4 each  beats minus one, one per requester.
REQ-007 req_ready  out  2  one-cycle pulse to the winner on the AR handshake.
REQ-008 resp_data  out  32  shared read-data return (mirrors rdata).
REQ-009 resp_valid  out  2  per-requester data-beat strobe.
REQ-010 resp_last  out  1  final beat of the current burst.
REQ-011 arid  out  4  {3'b0, winner index}.
REQ-012 araddr / arlen  out  32 / 4  registered burst address and length.
REQ-013 arsize / arburst  out  3 / 2  constants 3'b010 and 2'b01 (INCR).
REQ-014 arvalid  out  1  AXI address valid.
REQ-015 arready  in  1  AXI address ready.
REQ-016 rdata / rresp / rid / rlast / rvalid  in  32 / 2 / 4 / 1 / 1  AXI read-data channel.
REQ-017 rready  out  1  AXI read-data ready.

Function
REQ-018 FSM states: IDLE, ADDR, DATA; one outstanding burst at a time.
REQ-019 IDLE: if any req_valid bit is set, latch the winner index, address and length; go to ADDR.
REQ-020 Latency: arvalid rises the cycle after req_valid is first sampled in IDLE.
REQ-021 ADDR: arvalid=1; araddr/arlen/arid held stable until arready.
REQ-022 ADDR: on arvalid&&arready, pulse req_ready[winner] for exactly that cycle; go to DATA.
REQ-023 Requesters hold req_valid, address and length stable until their req_ready pulse.
REQ-024 DATA: rready=1.
REQ-025 DATA: resp_data=rdata; resp_valid[winner]=rvalid; resp_valid[other]=0; resp_last=rvalid&&rlast. Combinational, zero-cycle latency.
REQ-026 DATA: on rvalid&&rlast, return to IDLE. rready=0 in IDLE and ADDR.
REQ-027 rid and rresp are not checked; data is routed by the latched winner only.
REQ-028 Arbitration is decided only in IDLE and never changes mid-burst.
REQ-029 A new request raised during DATA waits in IDLE for at least one cycle.
REQ-030 A request on the losing side is not dropped; it stays pending until granted.

Reset
REQ-031 On reset: state=IDLE; arvalid, rready, req_ready, resp_valid, resp_last = 0; araddr, arlen, arid = 0; last_grant = 1.
REQ-032 Reset mid-burst aborts the transaction; beats of the aborted burst are not forwarded.

Configuration
REQ-033 Macro AXI_READ_ARB_ROUND_ROBIN_EN.
- Defined: when both sides request, the side not in last_grant wins; last_grant updates on each grant.
- Undefined: fixed priority, data side (bit1) always wins; last_grant is unused.

Verification
REQ-034 Single request: req_valid=2'b01, addr0=0x1FC00000, len0=3, arready=1 -> arvalid at cycle+1, arid=0, req_ready=2'b01 at the AR handshake; 4 beats on resp_valid[0]; resp_last on the 4th beat.
REQ-035 Simultaneous requests after reset, round-robin build: both sides request -> instruction side granted first, data side second (arid 0 then 1).
REQ-036 Simultaneous requests, fixed-priority build: both sides request -> data side (arid=1) granted first; instruction side granted after rlast.
REQ-037 Backpressure: arready low for 5 cycles -> arvalid, araddr, arlen stable throughout; no req_ready pulse until arready=1.
REQ-038 Reset during DATA after 2 of 8 beats -> next cycle state=IDLE, rready=0, no further resp_valid; a fresh request is granted normally.
